// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  // Bytes in the LEN header; also the number of bytes per program word.
  localparam int unsigned FRAME_LEN_BYTES = 4;
  localparam int unsigned LANE_W          = $clog2(FRAME_LEN_BYTES);

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in and memory write port out of the program loader.
interface program_loader_if;

  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;

  // Host / boot source side: drives bytes, observes the write port.
  modport master (
    output s_valid, s_data,
    input  s_ready, wr_en, wr_addr, wr_data
  );

  // Loader side.
  modport slave (
    input  s_valid, s_data,
    output s_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/program_loader_byte_packer.sv
// Packs bytes MSB-first into 32-bit words; flags the byte that completes a word.
module byte_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0]       held;
  logic [LANE_W-1:0] lane;

  // The completing byte is combined directly so the word is usable in the same cycle.
  assign word       = {held, in_data};
  assign word_valid = in_valid && (lane == LANE_W'(FRAME_LEN_BYTES - 1));

  // Shift in accepted bytes and track the lane; lane wraps 3->0 on each completed word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= '0;
      lane <= '0;
    end else if (clear) begin
      held <= '0;
      lane <= '0;
    end else if (in_valid) begin
      held <= {held[15:0], in_data};
      lane <= lane + LANE_W'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Receives a framed program image as a byte stream and writes it to
// instruction memory as 32-bit words, holding the core while loading.
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned MAX_WORDS = 2047,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  program_loader_if.slave  bus,
  output logic             busy,
  output logic             done,
  output logic             error
);

  state_t           state;
  logic [CNT_W-1:0] n_words;
  logic [CNT_W-1:0] idx;
  logic [7:0]       csum;

  logic             xfer;
  logic             pk_clear;
  logic             pk_valid;
  logic [31:0]      pk_word;

  // busy is registered and true exactly in LEN/DATA/CHK, so it doubles as ready.
  assign bus.s_ready = busy;
  assign xfer        = bus.s_valid && busy;
  assign pk_clear    = start && !busy;

  // The packer assembles both the LEN header and the payload words.
  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .in_valid   (xfer && (state == ST_LEN || state == ST_DATA)),
    .in_data    (bus.s_data),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  // Load sequencing, counters, checksum and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      n_words     <= '0;
      idx         <= '0;
      csum        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state   <= ST_LEN;
            busy    <= 1'b1;
            done    <= 1'b0;
            error   <= 1'b0;
            csum    <= '0;
            idx     <= '0;
            n_words <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LEN: begin
          if (xfer) begin
            csum <= csum ^ bus.s_data;
            if (pk_valid) begin
              n_words <= CNT_W'(pk_word);
              if (pk_word > 32'(MAX_WORDS)) begin
                state <= ST_ERR;
                busy  <= 1'b0;
                error <= 1'b1;
              end else if (pk_word == '0) begin
                state <= ST_CHK;
              end else begin
                state <= ST_DATA;
              end
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            csum <= csum ^ bus.s_data;
            if (pk_valid) begin
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= BASE_ADDR + 64'({idx, 2'b00});
              bus.wr_data <= pk_word;
              idx         <= idx + CNT_W'(1);
              if ((idx + CNT_W'(1)) == n_words) begin
                state <= ST_CHK;
              end
            end
          end
        end
        ST_CHK: begin
          if (xfer) begin
            busy <= 1'b0;
            if (bus.s_data == csum) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as bytes are driven
// and popped as the write port fires.
module tb_program_loader;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  localparam logic [63:0] BASE = 64'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, error;

  program_loader_if bus ();

  program_loader #(
    .BASE_ADDR (BASE),
    .MAX_WORDS (2047),
    .CNT_W     (32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  wr_t         exp_q[$];
  logic [31:0] payload[$];
  logic [7:0]  model_x;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write-port monitor and ready/busy coupling, sampled away from the active edge.
  always @(negedge clk) begin
    wr_t e;
    check("ready_eq_busy", {63'd0, bus.s_ready}, {63'd0, busy});
    if (bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", {32'd0, bus.wr_data}, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", bus.wr_addr, e.addr);
        check("wr_data", {32'd0, bus.wr_data}, {32'd0, e.data});
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // All drive tasks start and end at a falling edge.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned n;
    repeat (gap) begin
      bus.s_data = 8'($urandom);
      @(negedge clk);
    end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    n = 0;
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic send_tracked(input logic [7:0] b, input int unsigned maxgap);
    model_x ^= b;
    send_byte(b, $urandom_range(0, maxgap));
  endtask

  task automatic do_start();
    start   = 1'b1;
    model_x = 8'h00;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] n, input int unsigned maxgap);
    for (int i = 0; i < 4; i++) send_tracked(n[31-8*i -: 8], maxgap);
  endtask

  task automatic send_word(input int unsigned k, input logic [31:0] w, input int unsigned maxgap,
                           input int start_lane);
    wr_t e;
    e.addr = BASE + 64'(k) * 64'd4;
    e.data = w;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      if (i == start_lane) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
      end
      send_tracked(w[31-8*i -: 8], maxgap);
    end
  endtask

  task automatic finish_frame(input bit bad, input int unsigned maxgap);
    logic [7:0] sent;
    bit ok;
    sent = bad ? 8'h00 : model_x;
    ok   = (sent == model_x);
    send_byte(sent, $urandom_range(0, maxgap));
    check("done_after_chk", {63'd0, done}, {63'd0, ok});
    check("error_after_chk", {63'd0, error}, {63'd0, !ok});
    check("busy_after_chk", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("done_sticky", {63'd0, done}, {63'd0, ok});
    check("error_sticky", {63'd0, error}, {63'd0, !ok});
    check("all_writes_seen", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_frame(input int unsigned nw, input bit bad, input int unsigned maxgap,
                           input int start_word);
    do_start();
    check("busy_on_start", {63'd0, busy}, 64'd1);
    send_len(32'(nw), maxgap);
    for (int k = 0; k < int'(nw); k++)
      send_word(k, payload[k], maxgap, (k == start_word) ? 1 : -1);
    finish_frame(bad, maxgap);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    model_x     = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_wr_en", {63'd0, bus.wr_en}, 64'd0);
    check("rst_ready", {63'd0, bus.s_ready}, 64'd0);
    check("rst_wr_addr", bus.wr_addr, 64'd0);
    check("rst_wr_data", {32'd0, bus.wr_data}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two-word image, back-to-back bytes.
    payload = {32'h13000093, 32'h00100073};
    run_frame(2, 1'b0, 0, -1);

    // Same image with a wrong checksum byte: both writes still happen.
    run_frame(2, 1'b1, 0, -1);

    // LEN above the maximum: error right after the 4th header byte, no writes.
    do_start();
    send_len(32'h0000_0800, 0);
    check("toolong_error", {63'd0, error}, 64'd1);
    check("toolong_done", {63'd0, done}, 64'd0);
    check("toolong_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("toolong_sticky", {63'd0, error}, 64'd1);
    check("toolong_no_wr", 64'(exp_q.size()), 64'd0);

    // Empty image.
    payload = {};
    run_frame(0, 1'b0, 0, -1);

    // Start pulse in the middle of DATA must be ignored.
    payload = {};
    for (int i = 0; i < 3; i++) payload.push_back($urandom);
    run_frame(3, 1'b0, 0, 1);

    // Random valid gaps with garbage data while idle on the stream.
    payload = {};
    for (int i = 0; i < 6; i++) payload.push_back($urandom);
    run_frame(6, 1'b0, 3, -1);

    // Reset partway through word 3, then a clean reload from word 0.
    payload = {};
    for (int i = 0; i < 5; i++) payload.push_back($urandom);
    do_start();
    send_len(32'd5, 0);
    for (int k = 0; k < 3; k++) send_word(k, payload[k], 1, -1);
    send_tracked(8'hA5, 0);
    send_tracked(8'h5A, 0);
    rst = 1'b1;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_ready", {63'd0, bus.s_ready}, 64'd0);
    check("midrst_wr_en", {63'd0, bus.wr_en}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_error", {63'd0, error}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_prior_writes", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    payload = {32'h13000093, 32'h00100073};
    run_frame(2, 1'b0, 0, -1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
